// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding, grant identifiers and default timeout for the memory port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, DATA_BUSY = 2'd1, FETCH_BUSY = 2'd2} state_t;
   localparam logic GRANT_FETCH = 1'b0;
   localparam logic GRANT_DATA = 1'b1;
   localparam int MAX_WAIT_DEF = 15;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side requests/results and the memory-side strobes of the unified memory port.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic ifReq, dMemRead, dMemWrite, ifDone, dDone, stallPipe, stallFetch;
   logic memRe, memWe, memReady, errTimeout;
   logic [ADDR_W-1:0] ifAddr, dAddr, memAddr;
   logic [DATA_W-1:0] dWData, ifRData, dRData, memWData, memRData;
   modport master (
      input ifReq, ifAddr, dMemRead, dMemWrite, dAddr, dWData, memRData, memReady,
      output ifDone, ifRData, dDone, dRData, stallPipe, stallFetch, memAddr, memWData, memRe, memWe,
      errTimeout
   );
   modport slave (
      output ifReq, ifAddr, dMemRead, dMemWrite, dAddr, dWData, memRData, memReady,
      input ifDone, ifRData, dDone, dRData, stallPipe, stallFetch, memAddr, memWData, memRe, memWe,
      errTimeout
   );
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// wait_timer: counts busy cycles of one memory access and flags the cycle in which the wait budget runs out.
module wait_timer import mem_arb_pkg::*; #(parameter int MAX_WAIT = MAX_WAIT_DEF) (
   input  logic clock,
   input  logic nReset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [7:0] count;
   always_ff @(posedge clock or negedge nReset)
      if (!nReset) count <= '0;
      else if (clr) count <= '0;
      else if (en) count <= count + 8'd1;
   // true in the last allowed cycle: its edge would bring the count to MAX_WAIT
   assign expired = en && (count == 8'(MAX_WAIT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the unified memory between fetch and MEM-stage data accesses.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input logic clock,
   input logic nReset,
   mem_port_arbiter_if.master bus
);
   state_t state, state_n;
   logic last_grant, req_d, req_f, grant_d, grant_f, busy, expired, finish;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] rdata;
   // a requester whose done is pulsing is still the one just served, so it is not re-granted
   assign req_d = (bus.dMemRead | bus.dMemWrite) & ~bus.dDone;
   assign req_f = bus.ifReq & ~bus.ifDone;
   assign grant_d = req_d & (~req_f | last_grant == GRANT_FETCH);
   assign grant_f = req_f & ~grant_d;
   assign busy = state != IDLE;
   assign finish = busy & (bus.memReady | expired);
   assign grant_addr = grant_d ? bus.dAddr : bus.ifAddr;
   assign rdata = bus.memReady ? bus.memRData : '0;
   assign bus.stallPipe = req_d;
   assign bus.stallFetch = req_d | req_f;
   wait_timer #(.MAX_WAIT(MAX_WAIT)) timer (
      .clock(clock), .nReset(nReset), .clr(!busy), .en(busy), .expired(expired)
   );
   always_ff @(posedge clock or negedge nReset)
      if (!nReset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (!busy) state_n = grant_d ? DATA_BUSY : grant_f ? FETCH_BUSY : IDLE;
      else if (finish) state_n = IDLE;
   end
   always_ff @(posedge clock or negedge nReset)
      if (!nReset) begin
         bus.memAddr <= '0;
         bus.memWData <= '0;
         bus.memRe <= 1'b0;
         bus.memWe <= 1'b0;
         bus.ifDone <= 1'b0;
         bus.dDone <= 1'b0;
         bus.ifRData <= '0;
         bus.dRData <= '0;
         bus.errTimeout <= 1'b0;
         last_grant <= GRANT_FETCH;
      end else begin
         bus.ifDone <= finish && state == FETCH_BUSY;
         bus.dDone <= finish && state == DATA_BUSY;
         if (!busy && (grant_d || grant_f)) begin
            bus.memAddr <= grant_addr;
            if (grant_d && bus.dMemWrite) bus.memWData <= bus.dWData;
            bus.memWe <= grant_d & bus.dMemWrite;
            bus.memRe <= ~(grant_d & bus.dMemWrite);
            last_grant <= grant_d ? GRANT_DATA : GRANT_FETCH;
         end else if (finish) begin
            bus.memRe <= 1'b0;
            bus.memWe <= 1'b0;
         end
         // reads capture memory data, or zero on timeout; writes leave the load register alone
         if (finish && bus.memRe) begin
            if (state == FETCH_BUSY) bus.ifRData <= rdata;
            else bus.dRData <= rdata;
         end
         if (finish && !bus.memReady) bus.errTimeout <= 1'b1;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single accesses plus directed reset, idle-ready and contention sequences.
module tb_mem_port_arbiter;
   localparam int MW = 4;
   typedef struct {
      logic f, rd, wr;
      logic [31:0] addr, wdata, mdata;
      int lat, cycles;
      logic [31:0] rdata;
      logic to;
   } vec_t;
   logic clock = 0, nReset = 1, force_ready = 0;
   logic [31:0] mdata = 0;
   int lat = 0, cnt = 0, n_cmp = 0, n_bad = 0;
   vec_t tbl[7];
   logic [31:0] exp_a[4];
   mem_port_arbiter_if bus ();
   mem_port_arbiter #(.MAX_WAIT(MW)) dut (.clock(clock), .nReset(nReset), .bus(bus));
   always #5 clock = ~clock;
   // memory model: ready once the strobe has been up for lat cycles
   always @(posedge clock) cnt <= ((bus.memRe | bus.memWe) & ~bus.memReady) ? cnt + 1 : 0;
   assign bus.memReady = force_ready | ((bus.memRe | bus.memWe) & (cnt == lat));
   assign bus.memRData = mdata;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic run(input vec_t v);
      int n;
      logic seen;
      logic [1:0] se;
      se = (!v.f && v.wr) ? 2'b01 : 2'b10;
      bus.ifReq = v.f; bus.dMemRead = v.rd; bus.dMemWrite = v.wr;
      bus.ifAddr = v.addr; bus.dAddr = v.addr; bus.dWData = v.wdata;
      mdata = v.mdata; lat = v.lat;
      #1;
      chk("stall_req", {bus.stallPipe, bus.stallFetch}, v.f ? 2'b01 : 2'b11);
      n = 0;
      seen = 0;
      while (!seen && n < 20) begin
         step();
         n++;
         seen = v.f ? bus.ifDone : bus.dDone;
         if (!seen) begin
            chk("strobe_busy", {bus.memRe, bus.memWe}, se);
            chk("mem_addr", bus.memAddr, v.addr);
            chk("stall_busy", {bus.stallPipe, bus.stallFetch}, v.f ? 2'b01 : 2'b11);
         end
      end
      if (v.wr) chk("mem_wdata", bus.memWData, v.wdata);
      chk("latency", n, v.cycles);
      chk("rdata", v.f ? bus.ifRData : bus.dRData, v.rdata);
      chk("other_done", v.f ? bus.dDone : bus.ifDone, 0);
      chk("strobe_done", {bus.memRe, bus.memWe}, 0);
      chk("stall_done", {bus.stallPipe, bus.stallFetch}, 0);
      chk("err_timeout", bus.errTimeout, v.to);
      bus.ifReq = 0; bus.dMemRead = 0; bus.dMemWrite = 0;
      step();
      chk("after_done", {bus.ifDone, bus.dDone, bus.memRe, bus.memWe}, 0);
   endtask
   task automatic do_reset();
      @(posedge clock);
      #3 nReset = 0;
      @(posedge clock);
      #3 nReset = 1;
      step();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{0, 1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 1, 3, 32'hDEADBEEF, 0};
      tbl[1] = '{0, 1, 1, 32'h80, 32'h12345678, 32'hAAAA5555, 0, 2, 32'hDEADBEEF, 0};
      tbl[2] = '{1, 0, 0, 32'h100, 32'h0, 32'h00000013, 0, 2, 32'h00000013, 0};
      tbl[3] = '{0, 1, 0, 32'h44, 32'h0, 32'hCAFEF00D, 3, 5, 32'hCAFEF00D, 0};
      tbl[4] = '{1, 0, 0, 32'h104, 32'h0, 32'h55555555, 255, 5, 32'h0, 1};
      tbl[5] = '{0, 1, 0, 32'h48, 32'h0, 32'h0BADC0DE, 2, 4, 32'h0BADC0DE, 1};
      tbl[6] = '{1, 0, 0, 32'h108, 32'h0, 32'h00A00093, 0, 2, 32'h00A00093, 1};
      bus.ifReq = 0; bus.dMemRead = 0; bus.dMemWrite = 0;
      bus.ifAddr = 0; bus.dAddr = 0; bus.dWData = 0;
      #1 nReset = 0;
      #1;
      chk("rst_strobes", {bus.memRe, bus.memWe, bus.ifDone, bus.dDone, bus.errTimeout}, 0);
      chk("rst_addr", bus.memAddr, 0);
      chk("rst_wdata", bus.memWData, 0);
      chk("rst_ifrdata", bus.ifRData, 0);
      chk("rst_drdata", bus.dRData, 0);
      chk("rst_stall", {bus.stallPipe, bus.stallFetch}, 0);
      @(posedge clock);
      @(posedge clock);
      #3 nReset = 1;
      step();
      force_ready = 1;
      repeat (3) begin
         step();
         chk("idle_ready", {bus.ifDone, bus.dDone, bus.memRe, bus.memWe}, 0);
      end
      force_ready = 0;
      for (int i = 0; i < 7; i++) run(tbl[i]);
      bus.dMemRead = 1; bus.dAddr = 32'h60; lat = 255;
      step();
      chk("mid_grant", {bus.memRe, bus.memWe}, 2'b10);
      @(posedge clock);
      #3 nReset = 0;
      #1;
      chk("mid_async_drop", {bus.memRe, bus.memWe, bus.dDone}, 0);
      step();
      chk("mid_no_done", {bus.dDone, bus.ifDone}, 0);
      chk("mid_stall", {bus.stallPipe, bus.stallFetch}, 2'b11);
      chk("mid_err_clear", bus.errTimeout, 0);
      #2 nReset = 1;
      run('{0, 1, 0, 32'h64, 32'h0, 32'h77665544, 1, 3, 32'h77665544, 0});
      do_reset();
      exp_a[0] = 32'h300; exp_a[1] = 32'h200; exp_a[2] = 32'h300; exp_a[3] = 32'h200;
      bus.ifReq = 1; bus.ifAddr = 32'h200; bus.dMemRead = 1; bus.dAddr = 32'h300;
      lat = 0; mdata = 32'h11110000;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rr_addr", bus.memAddr, exp_a[k]);
         chk("rr_strobe", {bus.memRe, bus.memWe, bus.ifDone, bus.dDone}, 4'b1000);
         step();
         chk("rr_done", {bus.memRe, bus.memWe, bus.ifDone, bus.dDone}, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      end
      bus.ifReq = 0; bus.dMemRead = 0;
      step();
      chk("rr_idle", {bus.memRe, bus.memWe, bus.ifDone, bus.dDone}, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
